// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
//               Holds the FSM state encoding, the zero-register specifier, and
//               the upper bound on the load-use stall length.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

   // Controller FSM: normal flow, or holding the front end after a load-use
   typedef enum logic {
      RUN     = 1'b0,
      LDSTALL = 1'b1
   } hz_state_e;

   // Register $0 is hard-wired to zero, so a load to it never creates a hazard
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Largest stall length representable by the 3-bit stall down-counter
   localparam int MAX_LOAD_STALL = 7;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating event counter with synchronous clear.
//               The count sticks at all-ones instead of wrapping. A clear
//               wins over an increment arriving in the same cycle.
// Ports       : clk - rising-edge clock
//               rst - synchronous active-high reset (count -> 0)
//               clr - synchronous clear (count -> 0)
//               inc - count one event this cycle
//               q   - current count [WIDTH-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign q = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for the 5-stage core. Detects
//               load-use hazards and holds PC / IF/ID for LOAD_STALL_CYCLES
//               cycles while bubbling ID/EX, flushes IF/ID on taken
//               branches/jumps resolved in ID, and counts both event kinds.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               if_id_rs/rt      - source specifiers of the ID instruction
//               if_id_uses_rt    - ID instruction actually reads rt
//               id_ex_mem_read   - EX instruction is a load
//               id_ex_rt         - destination register of that load
//               branch_taken     - ID branch/jump resolved taken
//               count_clr        - clear both event counters
//               pc_write, if_id_write, if_id_flush, id_ex_bubble
//                                - same-cycle pipeline register controls
//               stall_count, flush_count - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int COUNT_W           = 16,
   parameter int REG_W             = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [REG_W-1:0]   if_id_rs,
   input  logic [REG_W-1:0]   if_id_rt,
   input  logic               if_id_uses_rt,
   input  logic               id_ex_mem_read,
   input  logic [REG_W-1:0]   id_ex_rt,
   input  logic               branch_taken,
   input  logic               count_clr,
   output logic               pc_write,
   output logic               if_id_write,
   output logic               if_id_flush,
   output logic               id_ex_bubble,
   output logic [COUNT_W-1:0] stall_count,
   output logic [COUNT_W-1:0] flush_count
);

   // Out-of-range stall lengths are clamped into the legal 1..7 window
   localparam int c_stall_cycles = (LOAD_STALL_CYCLES < 1)              ? 1 :
                                   (LOAD_STALL_CYCLES > MAX_LOAD_STALL) ? MAX_LOAD_STALL :
                                                                          LOAD_STALL_CYCLES;
   // The hazard cycle itself is the first hold cycle; scnt covers the rest
   localparam logic [2:0] c_scnt_init = 3'(c_stall_cycles - 1);

   hz_state_e  state_q, state_d;
   logic [2:0] scnt_q,  scnt_d;
   logic       hz;
   logic       stall_inc;
   logic       flush_inc;

   assign hz = id_ex_mem_read
             && (id_ex_rt != REG_W'(REG_ZERO))
             && ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      state_d      = state_q;
      scnt_d       = scnt_q;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;

      if (rst) begin
         // Write+Flush drains IF/ID while the PC is frozen
         pc_write     = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         state_d      = RUN;
         scnt_d       = 3'd0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (hz) begin
                  // Branch is dropped here: its operands may come from the load
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
                  stall_inc    = 1'b1;
                  if (c_stall_cycles > 1) begin
                     state_d = LDSTALL;
                     scnt_d  = c_scnt_init;
                  end
               end else if (branch_taken) begin
                  if_id_flush = 1'b1;
                  flush_inc   = 1'b1;
               end
            end
            LDSTALL: begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
               scnt_d       = scnt_q - 3'd1;
               if (scnt_q == 3'd1) begin
                  state_d = RUN;
               end
            end
            default: begin
               state_d = RUN;
               scnt_d  = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         scnt_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
      end
   end

   sat_counter #(
      .WIDTH (COUNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .clr (count_clr),
      .inc (stall_inc),
      .q   (stall_count)
   );

   sat_counter #(
      .WIDTH (COUNT_W)
   ) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .clr (count_clr),
      .inc (flush_inc),
      .q   (flush_count)
   );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Two instances share one
//               stimulus stream: dut_a (1-cycle stall, 16-bit counters) and
//               dut_b (3-cycle stall, 4-bit counters). A behavioural model
//               tracks remaining hold cycles and event totals per instance.
//               Control vector layout: {pc_write, if_id_write, if_id_flush,
//               id_ex_bubble}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] if_id_rs = '0;
   logic [4:0] if_id_rt = '0;
   logic       if_id_uses_rt = 1'b0;
   logic       id_ex_mem_read = 1'b0;
   logic [4:0] id_ex_rt = '0;
   logic       branch_taken = 1'b0;
   logic       count_clr = 1'b0;

   logic        pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a;
   logic [15:0] stall_count_a, flush_count_a;
   logic        pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b;
   logic [3:0]  stall_count_b, flush_count_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.LOAD_STALL_CYCLES(1), .COUNT_W(16), .REG_W(5)) dut_a (
      .clk(clk), .rst(rst), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
      .if_id_uses_rt(if_id_uses_rt), .id_ex_mem_read(id_ex_mem_read),
      .id_ex_rt(id_ex_rt), .branch_taken(branch_taken), .count_clr(count_clr),
      .pc_write(pc_write_a), .if_id_write(if_id_write_a), .if_id_flush(if_id_flush_a),
      .id_ex_bubble(id_ex_bubble_a), .stall_count(stall_count_a), .flush_count(flush_count_a));

   hazard_ctrl #(.LOAD_STALL_CYCLES(3), .COUNT_W(4), .REG_W(5)) dut_b (
      .clk(clk), .rst(rst), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
      .if_id_uses_rt(if_id_uses_rt), .id_ex_mem_read(id_ex_mem_read),
      .id_ex_rt(id_ex_rt), .branch_taken(branch_taken), .count_clr(count_clr),
      .pc_write(pc_write_b), .if_id_write(if_id_write_b), .if_id_flush(if_id_flush_b),
      .id_ex_bubble(id_ex_bubble_b), .stall_count(stall_count_b), .flush_count(flush_count_b));

   wire [3:0] ctl_a = {pc_write_a, if_id_write_a, if_id_flush_a, id_ex_bubble_a};
   wire [3:0] ctl_b = {pc_write_b, if_id_write_b, if_id_flush_b, id_ex_bubble_b};

   // ---------------- reference model ----------------
   int hold_a = 0, sc_a = 0, fc_a = 0;
   int hold_b = 0, sc_b = 0, fc_b = 0;
   int nhold_a, nsc_a, nfc_a, nhold_b, nsc_b, nfc_b;
   logic [3:0] exp_ctl_a, exp_ctl_b;

   function automatic bit hz_ref();
      return id_ex_mem_read && (id_ex_rt != 0) &&
             ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
   endfunction

   // hold = number of further cycles the front end stays frozen
   task automatic model_one(input int lsc, input int maxc, input int hold, input int sc,
                            input int fc, output logic [3:0] ctl, output int nhold,
                            output int nsc, output int nfc);
      nhold = hold; nsc = sc; nfc = fc;
      if (rst) begin
         ctl = 4'b0111; nhold = 0; nsc = 0; nfc = 0;
      end else begin
         if (hold > 0) begin
            ctl = 4'b0001; nhold = hold - 1;
         end else if (hz_ref()) begin
            ctl = 4'b0001; nhold = lsc - 1;
            if (nsc < maxc) nsc = nsc + 1;
         end else if (branch_taken) begin
            ctl = 4'b1110;
            if (nfc < maxc) nfc = nfc + 1;
         end else begin
            ctl = 4'b1100;
         end
         if (count_clr) begin nsc = 0; nfc = 0; end
      end
   endtask

   task automatic model_eval();
      model_one(1, 65535, hold_a, sc_a, fc_a, exp_ctl_a, nhold_a, nsc_a, nfc_a);
      model_one(3, 15,    hold_b, sc_b, fc_b, exp_ctl_b, nhold_b, nsc_b, nfc_b);
   endtask

   // Evaluate the model on settled inputs, take the clock edge, commit model state
   task automatic advance();
      model_eval();
      @(posedge clk);
      hold_a = nhold_a; sc_a = nsc_a; fc_a = nfc_a;
      hold_b = nhold_b; sc_b = nsc_b; fc_b = nfc_b;
      #1;
   endtask

   task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic br);
      id_ex_mem_read = mr; id_ex_rt = ert; if_id_rs = rs; if_id_rt = rt;
      if_id_uses_rt = urt; branch_taken = br;
   endtask

   task automatic apply_reset();
      set_in(0, 0, 0, 0, 0, 0); count_clr = 0;
      rst = 1; advance(); rst = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1; set_in(0, 0, 0, 0, 0, 0); #3; model_eval();
      n_tests++; if (ctl_a !== 4'b0111) begin n_fail++; $display("FAIL reset_ctl_a got %b want %b", ctl_a, 4'b0111); end
      n_tests++; if (ctl_b !== 4'b0111) begin n_fail++; $display("FAIL reset_ctl_b got %b want %b", ctl_b, 4'b0111); end
      advance(); rst = 0; #3;
      n_tests++; if (stall_count_a !== 16'd0 || flush_count_a !== 16'd0) begin n_fail++; $display("FAIL reset_cnt_a got %0d/%0d want 0/0", stall_count_a, flush_count_a); end
      n_tests++; if (stall_count_b !== 4'd0 || flush_count_b !== 4'd0) begin n_fail++; $display("FAIL reset_cnt_b got %0d/%0d want 0/0", stall_count_b, flush_count_b); end
      n_tests++; if (ctl_a !== 4'b1100) begin n_fail++; $display("FAIL run_idle_a got %b want %b", ctl_a, 4'b1100); end
      advance();
   endtask

   task automatic test_load_use();
      apply_reset();
      set_in(1, 5'd2, 5'd2, 5'd0, 0, 0); #3; model_eval();
      n_tests++; if (ctl_a !== 4'b0001) begin n_fail++; $display("FAIL load_use_stall_a got %b want %b", ctl_a, 4'b0001); end
      n_tests++; if (ctl_b !== 4'b0001) begin n_fail++; $display("FAIL load_use_stall_b got %b want %b", ctl_b, 4'b0001); end
      advance();
      set_in(0, 5'd2, 5'd2, 5'd0, 0, 0); #3; model_eval();
      n_tests++; if (ctl_a !== 4'b1100) begin n_fail++; $display("FAIL load_use_resume_a got %b want %b", ctl_a, 4'b1100); end
      n_tests++; if (stall_count_a !== 16'd1) begin n_fail++; $display("FAIL load_use_count_a got %0d want 1", stall_count_a); end
      n_tests++; if (ctl_b !== exp_ctl_b) begin n_fail++; $display("FAIL load_use_hold_b got %b want %b", ctl_b, exp_ctl_b); end
      advance();
   endtask

   task automatic test_no_hazard();
      apply_reset();
      set_in(1, 5'd0, 5'd0, 5'd0, 1, 0); #3;
      n_tests++; if (ctl_a !== 4'b1100) begin n_fail++; $display("FAIL zero_reg_a got %b want %b", ctl_a, 4'b1100); end
      advance();
      set_in(1, 5'd3, 5'd1, 5'd3, 0, 0); #3;
      n_tests++; if (ctl_a !== 4'b1100) begin n_fail++; $display("FAIL rt_unused_a got %b want %b", ctl_a, 4'b1100); end
      advance();
      set_in(1, 5'd3, 5'd1, 5'd3, 1, 0); #3;
      n_tests++; if (ctl_a !== 4'b0001) begin n_fail++; $display("FAIL rt_used_a got %b want %b", ctl_a, 4'b0001); end
      advance();
   endtask

   task automatic test_branch();
      apply_reset();
      set_in(0, 0, 0, 0, 0, 1); #3;
      n_tests++; if (ctl_a !== 4'b1110) begin n_fail++; $display("FAIL branch_ctl_a got %b want %b", ctl_a, 4'b1110); end
      n_tests++; if (ctl_b !== 4'b1110) begin n_fail++; $display("FAIL branch_ctl_b got %b want %b", ctl_b, 4'b1110); end
      advance();
      set_in(0, 0, 0, 0, 0, 0); #3;
      n_tests++; if (flush_count_a !== 16'd1) begin n_fail++; $display("FAIL branch_cnt_a got %0d want 1", flush_count_a); end
      advance();
   endtask

   task automatic test_hz_branch();
      apply_reset();
      set_in(1, 5'd4, 5'd4, 5'd0, 0, 1); #3;
      n_tests++; if (ctl_a !== 4'b0001) begin n_fail++; $display("FAIL hz_br_ctl_a got %b want %b", ctl_a, 4'b0001); end
      advance();
      set_in(0, 5'd4, 5'd4, 5'd0, 0, 1); #3;
      n_tests++; if (flush_count_a !== 16'd0 || stall_count_a !== 16'd1) begin n_fail++; $display("FAIL hz_br_cnt_a got %0d/%0d want 1/0", stall_count_a, flush_count_a); end
      n_tests++; if (ctl_a !== 4'b1110) begin n_fail++; $display("FAIL hz_br_reflush_a got %b want %b", ctl_a, 4'b1110); end
      n_tests++; if (ctl_b !== 4'b0001) begin n_fail++; $display("FAIL hz_br_held_b got %b want %b", ctl_b, 4'b0001); end
      advance();
      set_in(0, 0, 0, 0, 0, 0); #3;
      n_tests++; if (flush_count_a !== 16'd1) begin n_fail++; $display("FAIL hz_br_fcnt_a got %0d want 1", flush_count_a); end
      n_tests++; if (flush_count_b !== 4'd0) begin n_fail++; $display("FAIL hz_br_fcnt_b got %0d want 0", flush_count_b); end
      advance();
   endtask

   task automatic test_rst_mid_stall();
      apply_reset();
      set_in(1, 5'd6, 5'd6, 5'd0, 0, 0); #3;
      n_tests++; if (ctl_b !== 4'b0001) begin n_fail++; $display("FAIL mid_rst_c1_b got %b want %b", ctl_b, 4'b0001); end
      advance();
      set_in(0, 0, 0, 0, 0, 0); rst = 1; #3;
      n_tests++; if (ctl_b !== 4'b0111) begin n_fail++; $display("FAIL mid_rst_c2_b got %b want %b", ctl_b, 4'b0111); end
      advance();
      rst = 0; #3;
      n_tests++; if (ctl_b !== 4'b1100) begin n_fail++; $display("FAIL mid_rst_c3_b got %b want %b", ctl_b, 4'b1100); end
      n_tests++; if (stall_count_b !== 4'd0 || flush_count_b !== 4'd0) begin n_fail++; $display("FAIL mid_rst_cnt_b got %0d/%0d want 0/0", stall_count_b, flush_count_b); end
      advance();
   endtask

   task automatic test_saturate();
      apply_reset();
      // 60 cycles of a standing hazard = 20 separate 3-cycle events on dut_b
      set_in(1, 5'd7, 5'd7, 5'd0, 0, 0);
      for (int i = 0; i < 60; i++) advance();
      #3;
      n_tests++; if (stall_count_b !== 4'd15) begin n_fail++; $display("FAIL sat_stall_b got %0d want 15", stall_count_b); end
      n_tests++; if (stall_count_a !== 16'd60) begin n_fail++; $display("FAIL sat_stall_a got %0d want 60", stall_count_a); end
      count_clr = 1; advance(); count_clr = 0; set_in(0, 0, 0, 0, 0, 0); #3;
      n_tests++; if (stall_count_b !== 4'd0) begin n_fail++; $display("FAIL clr_prio_b got %0d want 0", stall_count_b); end
      n_tests++; if (stall_count_a !== 16'd0) begin n_fail++; $display("FAIL clr_prio_a got %0d want 0", stall_count_a); end
      n_tests++; if (ctl_b !== exp_ctl_b) begin n_fail++; $display("FAIL clr_fsm_b got %b want %b", ctl_b, exp_ctl_b); end
      advance();
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         rst            = ($urandom_range(0, 39) == 0);
         count_clr      = ($urandom_range(0, 19) == 0);
         id_ex_mem_read = ($urandom_range(0, 1) == 1);
         id_ex_rt       = 5'($urandom_range(0, 3));
         if_id_rs       = 5'($urandom_range(0, 3));
         if_id_rt       = 5'($urandom_range(0, 3));
         if_id_uses_rt  = ($urandom_range(0, 1) == 1);
         branch_taken   = ($urandom_range(0, 3) == 0);
         #3; model_eval();
         n_tests++; if (ctl_a !== exp_ctl_a) begin n_fail++; $display("FAIL rand_ctl_a cyc %0d got %b want %b", i, ctl_a, exp_ctl_a); end
         n_tests++; if (ctl_b !== exp_ctl_b) begin n_fail++; $display("FAIL rand_ctl_b cyc %0d got %b want %b", i, ctl_b, exp_ctl_b); end
         n_tests++; if (stall_count_a !== 16'(sc_a) || flush_count_a !== 16'(fc_a)) begin n_fail++; $display("FAIL rand_cnt_a cyc %0d got %0d/%0d want %0d/%0d", i, stall_count_a, flush_count_a, sc_a, fc_a); end
         n_tests++; if (stall_count_b !== 4'(sc_b) || flush_count_b !== 4'(fc_b)) begin n_fail++; $display("FAIL rand_cnt_b cyc %0d got %0d/%0d want %0d/%0d", i, stall_count_b, flush_count_b, sc_b, fc_b); end
         advance();
      end
      rst = 0; count_clr = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_load_use();
      test_no_hazard();
      test_branch();
      test_hz_branch();
      test_rst_mid_stall();
      test_saturate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_hazard_ctrl
`default_nettype wire
